alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Combined instruction decoder and 8-bit ALU for the lab CPU datapath.
- Splits a 16-bit instruction into ALU opcode, two register addresses and show/write controls.
- Computes the 8-bit result combinationally from two register-bank operands.
- Holds the CF/ZF/SF/OF status flags and the last shown result in registers on a single clock.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.

Ports:
- i_CLK  input  1  system clock, rising edge.
- i_SYS_RESET  input  1  synchronous active-high reset.
- i_instr  input  16  instruction word.
- i_in1  input  8  operand 1 (register at addr1).
- i_in2  input  8  operand 2 (register at addr2).
- o_alu_op  output  4  decoded opcode, instr[15:12].
- o_addr1  output  3  src1/dest register address, instr[11:9].
- o_addr2  output  3  src2 register address, instr[8:6].
- o_show  output  1  result is displayed.
- o_write  output  1  result is written back to addr1.
- o_res  output  8  combinational ALU result.
- o_CF, o_ZF, o_SF, o_OF  output  1 each  registered status flags.
- o_shown  output  8  registered last shown result.

Behaviour:
- Clocking and reset:
  - One clock domain; everything sequential updates on rising i_CLK.
  - Reset is synchronous, active-high, and takes priority over all updates.
  - Reset values: o_CF = o_ZF = o_SF = o_OF = 0; o_shown = 0x00.
- Decode (combinational, zero latency):
  - instr[5:0] are ignored.
  - o_write = 1 for every opcode except 0x0 (NOP) and 0xE (CMP).
  - o_show = 1 for every opcode except 0x0.
- Opcodes (in1 = A, in2 = B):
  - 0 NOP: res = 0.
  - 1 ADD: res = A+B.
  - 2 SUB: res = A−B.
  - 3 AND, 4 OR, 5 XOR.
  - 6 NOT: res = ~A.
  - 7 SHL: A<<1.
  - 8 SHR: logical A>>1.
  - 9 SAR: arithmetic A>>1.
  - A ROL: rotate A left by 1.
  - B ROR: rotate A right by 1.
  - C INC: A+1.
  - D DEC: A−1.
  - E CMP: A−B, result not written back.
  - F MOV: res = B.
  - All arithmetic is modulo 256.
- Flag computation (combinational from o_res):
  - ZF = (res == 0); SF = res[7].
  - CF:
    - ADD/INC: carry out of bit 7.
    - SUB/CMP/DEC: borrow, i.e. A < subtrahend (unsigned).
    - SHL and ROL: A[7].
    - SHR, SAR and ROR: A[0].
    - All other opcodes: 0.
  - OF:
    - ADD/INC: operands have the same sign and the result sign differs.
    - SUB/CMP/DEC: operand signs differ and the result sign differs from A.
    - SHL: res[7] XOR CF.
    - All other opcodes: 0.
- Flag register:
  - On a clock edge without reset and opcode ≠ NOP: the four flag registers load the computed flags.
  - For NOP: flags hold their previous values.
- o_shown loads o_res on each clock edge where o_show = 1; otherwise it holds.
- Outputs o_res, o_alu_op, o_addr1, o_addr2, o_show and o_write change combinationally with inputs, unaffected by reset.
- Boundary cases:
  - 0xFF INC → 0x00 with CF = 1, ZF = 1, OF = 0.
  - 0x80 DEC → 0x7F with OF = 1, CF = 0.
  - 0x7F INC → 0x80 with OF = 1.
  - Reset asserted in the same cycle as a flag-updating instruction: reset wins, flags = 0.
- No X propagation: every opcode drives a defined result and defined flags.

Test Plan:
- Decode: instr = 0x1280 → o_alu_op = 1, o_addr1 = 1, o_addr2 = 2, o_write = 1, o_show = 1. instr = 0xE000 → o_write = 0. instr = 0x0000 → o_show = 0, o_write = 0.
- ADD overflow: instr op 1, A = 0x7F, B = 0x01 → o_res = 0x80; after clock CF = 0, ZF = 0, SF = 1, OF = 1; o_shown = 0x80.
- SUB borrow and CMP:
  - SUB A = 0x00, B = 0x01 → res 0xFF, CF = 1, SF = 1, OF = 0.
  - CMP A = 0x05, B = 0x05 → res 0x00, ZF = 1, CF = 0, o_write = 0.
- Shifts/rotates:
  - SHR 0x81 → 0x40, CF = 1.
  - SAR 0x81 → 0xC0, CF = 1.
  - ROL 0x81 → 0x03, CF = 1.
  - SHL 0x40 → 0x80, CF = 0, OF = 1.
- NOP hold: set flags via ADD 0xFF+0x01 (res 0x00, CF = 1, ZF = 1), then clock a NOP → flags unchanged, o_shown unchanged.
- Reset: with flags nonzero, assert i_SYS_RESET for 1 cycle alongside an ADD → all flags 0 and o_shown = 0x00 after the edge; o_res still shows the combinational sum.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: instruction decoder plus 8-bit ALU with registered status flags and shown result
// Ports: i_CLK/i_SYS_RESET clock and sync active-high reset; i_instr instruction word;
//        i_in1/i_in2 operands; o_alu_op/o_addr1/o_addr2/o_show/o_write decoded fields;
//        o_res combinational result; o_CF/o_ZF/o_SF/o_OF registered flags; o_shown last shown result.
module alu_exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              i_CLK,
    input  logic              i_SYS_RESET,
    input  logic [15:0]       i_instr,
    input  logic [DATA_W-1:0] i_in1,
    input  logic [DATA_W-1:0] i_in2,
    output logic [3:0]        o_alu_op,
    output logic [2:0]        o_addr1,
    output logic [2:0]        o_addr2,
    output logic              o_show,
    output logic              o_write,
    output logic [DATA_W-1:0] o_res,
    output logic              o_CF,
    output logic              o_ZF,
    output logic              o_SF,
    output logic              o_OF,
    output logic [DATA_W-1:0] o_shown
);
    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, AND = 4'h3, OR  = 4'h4, XOR = 4'h5,
                           NOT = 4'h6, SHL = 4'h7, SHR = 4'h8, SAR = 4'h9, ROL = 4'hA, ROR = 4'hB,
                           INC = 4'hC, DEC = 4'hD, CMP = 4'hE, MOV = 4'hF;
    logic [DATA_W-1:0] a, b, opnd;
    logic [DATA_W:0]   add_w, sub_w;
    logic              cf, of, is_add, is_sub;
    logic [3:0]        flags_d, flags_q;
    logic [DATA_W-1:0] shown_d, shown_q;
    logic              unused;
    assign unused   = ^i_instr[5:0];
    assign a        = i_in1;
    assign b        = i_in2;
    assign o_alu_op = i_instr[15:12];
    assign o_addr1  = i_instr[11:9];
    assign o_addr2  = i_instr[8:6];
    assign o_show   = o_alu_op != NOP;
    assign o_write  = o_alu_op != NOP && o_alu_op != CMP;
    assign is_add   = o_alu_op == ADD || o_alu_op == INC;
    assign is_sub   = o_alu_op == SUB || o_alu_op == CMP || o_alu_op == DEC;
    // INC/DEC share the adder/subtractor with a constant-one second operand
    assign opnd     = (o_alu_op == INC || o_alu_op == DEC) ? DATA_W'(1) : b;
    assign add_w    = {1'b0, a} + {1'b0, opnd};
    assign sub_w    = {1'b0, a} - {1'b0, opnd};
    always_comb begin
        case (o_alu_op)
            ADD, INC:      o_res = add_w[DATA_W-1:0];
            SUB, DEC, CMP: o_res = sub_w[DATA_W-1:0];
            AND:           o_res = a & b;
            OR:            o_res = a | b;
            XOR:           o_res = a ^ b;
            NOT:           o_res = ~a;
            SHL:           o_res = {a[DATA_W-2:0], 1'b0};
            SHR:           o_res = {1'b0, a[DATA_W-1:1]};
            SAR:           o_res = {a[DATA_W-1], a[DATA_W-1:1]};
            ROL:           o_res = {a[DATA_W-2:0], a[DATA_W-1]};
            ROR:           o_res = {a[0], a[DATA_W-1:1]};
            MOV:           o_res = b;
            default:       o_res = '0;
        endcase
    end
    // The top bit of the 9-bit difference is the unsigned borrow (A < subtrahend)
    always_comb begin
        cf = is_add ? add_w[DATA_W] :
             is_sub ? sub_w[DATA_W] :
             (o_alu_op == SHL || o_alu_op == ROL) ? a[DATA_W-1] :
             (o_alu_op == SHR || o_alu_op == SAR || o_alu_op == ROR) ? a[0] : 1'b0;
        of = is_add ? (a[DATA_W-1] == opnd[DATA_W-1]) && (o_res[DATA_W-1] != a[DATA_W-1]) :
             is_sub ? (a[DATA_W-1] != opnd[DATA_W-1]) && (o_res[DATA_W-1] != a[DATA_W-1]) :
             (o_alu_op == SHL) ? o_res[DATA_W-1] ^ a[DATA_W-1] : 1'b0;
    end
    assign flags_d = (o_alu_op != NOP) ? {cf, o_res == '0, o_res[DATA_W-1], of} : flags_q;
    assign shown_d = o_show ? o_res : shown_q;
    always_ff @(posedge i_CLK) begin
        if (i_SYS_RESET) begin
            flags_q <= '0;
            shown_q <= '0;
        end else begin
            flags_q <= flags_d;
            shown_q <= shown_d;
        end
    end
    assign {o_CF, o_ZF, o_SF, o_OF} = flags_q;
    assign o_shown = shown_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a queue-based scoreboard for alu_exec_unit
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [7:0]  in1, in2;
    logic [3:0]  alu_op;
    logic [2:0]  addr1, addr2;
    logic        show, write;
    logic [7:0]  res, shown;
    logic        cf, zf, sf, of;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [15:0] instr;
        logic [7:0] res;
        logic       show;
        logic       write;
        logic [3:0] flags;
        logic [7:0] shown;
    } exp_t;
    exp_t sb[$];

    alu_exec_unit #(.DATA_W(8)) dut (
        .i_CLK(clk), .i_SYS_RESET(rst), .i_instr(instr), .i_in1(in1), .i_in2(in2),
        .o_alu_op(alu_op), .o_addr1(addr1), .o_addr2(addr2), .o_show(show), .o_write(write),
        .o_res(res), .o_CF(cf), .o_ZF(zf), .o_SF(sf), .o_OF(of), .o_shown(shown)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: each clocked vector is checked 1 time unit after its edge, while inputs are still held
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, "res",    16'(res),    16'(e.res));
            check(e.name, "alu_op", 16'(alu_op), 16'(e.instr[15:12]));
            check(e.name, "addr1",  16'(addr1),  16'(e.instr[11:9]));
            check(e.name, "addr2",  16'(addr2),  16'(e.instr[8:6]));
            check(e.name, "show",   16'(show),   16'(e.show));
            check(e.name, "write",  16'(write),  16'(e.write));
            check(e.name, "flags_CZSO", 16'({cf, zf, sf, of}), 16'(e.flags));
            check(e.name, "shown",  16'(shown),  16'(e.shown));
        end
    end

    task automatic vec(input string name, input logic r, input logic [15:0] ins, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e_res, input logic e_show, input logic e_write,
                       input logic [3:0] e_flags, input logic [7:0] e_shown);
        exp_t e;
        @(negedge clk);
        rst = r; instr = ins; in1 = a; in2 = b;
        e.name = name; e.instr = ins; e.res = e_res; e.show = e_show; e.write = e_write;
        e.flags = e_flags; e.shown = e_shown;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; instr = '0; in1 = '0; in2 = '0;
        //   name          rst ins       A      B      res    sh wr  CZSO     shown
        vec("reset",       1, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 4'b0000, 8'h00);
        vec("add_ovf",     0, 16'h1280, 8'h7F, 8'h01, 8'h80, 1, 1, 4'b0011, 8'h80);
        vec("sub_borrow",  0, 16'h2000, 8'h00, 8'h01, 8'hFF, 1, 1, 4'b1010, 8'hFF);
        vec("cmp_eq",      0, 16'hE000, 8'h05, 8'h05, 8'h00, 1, 0, 4'b0100, 8'h00);
        vec("shr",         0, 16'h8000, 8'h81, 8'h00, 8'h40, 1, 1, 4'b1000, 8'h40);
        vec("sar",         0, 16'h9000, 8'h81, 8'h00, 8'hC0, 1, 1, 4'b1010, 8'hC0);
        vec("rol",         0, 16'hA000, 8'h81, 8'h00, 8'h03, 1, 1, 4'b1000, 8'h03);
        vec("shl",         0, 16'h7000, 8'h40, 8'h00, 8'h80, 1, 1, 4'b0011, 8'h80);
        vec("inc_wrap",    0, 16'hC000, 8'hFF, 8'h00, 8'h00, 1, 1, 4'b1100, 8'h00);
        vec("dec_ovf",     0, 16'hD000, 8'h80, 8'h00, 8'h7F, 1, 1, 4'b0001, 8'h7F);
        vec("inc_ovf",     0, 16'hC000, 8'h7F, 8'h00, 8'h80, 1, 1, 4'b0011, 8'h80);
        vec("add_carry",   0, 16'h1000, 8'hFF, 8'h01, 8'h00, 1, 1, 4'b1100, 8'h00);
        vec("nop_hold1",   0, 16'h0000, 8'h12, 8'h34, 8'h00, 0, 0, 4'b1100, 8'h00);
        vec("xor",         0, 16'h5000, 8'hFF, 8'h0F, 8'hF0, 1, 1, 4'b0010, 8'hF0);
        vec("nop_hold2",   0, 16'h003F, 8'h55, 8'hAA, 8'h00, 0, 0, 4'b0010, 8'hF0);
        vec("ror",         0, 16'hB000, 8'h01, 8'h00, 8'h80, 1, 1, 4'b1010, 8'h80);
        vec("and",         0, 16'h3000, 8'hF0, 8'h3C, 8'h30, 1, 1, 4'b0000, 8'h30);
        vec("or",          0, 16'h4000, 8'hF0, 8'h0C, 8'hFC, 1, 1, 4'b0010, 8'hFC);
        vec("not",         0, 16'h6000, 8'h0F, 8'h00, 8'hF0, 1, 1, 4'b0010, 8'hF0);
        vec("mov",         0, 16'hF000, 8'h11, 8'h5A, 8'h5A, 1, 1, 4'b0000, 8'h5A);
        vec("add_ign_lo",  0, 16'h1E7F, 8'hFF, 8'h02, 8'h01, 1, 1, 4'b1000, 8'h01);
        vec("rst_vs_add",  1, 16'h1000, 8'h10, 8'h20, 8'h30, 1, 1, 4'b0000, 8'h00);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
